// File: rtl/fas_stream_checker.sv
// Streaming result checker: compares DUT beats against an expected-value memory with a
// modular +/-TOL tolerance per half-word, keeps pass/fail statistics and aborts at a fail limit.
module fas_stream_checker #(
    parameter int unsigned DW         = 16,
    parameter int unsigned LANES      = 16,
    parameter int unsigned CPLX       = 1,
    parameter int unsigned TOL        = 3,
    parameter int unsigned FAIL_LIMIT = 48,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned AW         = 6,
    parameter int unsigned CW         = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         dut_valid_i,
    input  logic [LANES*(CPLX+1)*DW-1:0] dut_data_i,
    output logic [AW-1:0]                exp_addr_o,
    input  logic [LANES*(CPLX+1)*DW-1:0] exp_data_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         pass_o,
    output logic                         fail_o,
    output logic [CW-1:0]                fail_cnt_o,
    output logic [AW:0]                  beat_cnt_o,
    output logic [AW-1:0]                first_fail_beat_o,
    output logic                         overflow_o
);

    localparam int unsigned NH = LANES * (CPLX + 1);
    localparam int unsigned BW = NH * DW;
    localparam int unsigned MW = $clog2(NH + 1);

    localparam logic signed [DW-1:0] TolPos   = DW'(TOL);
    localparam logic signed [DW-1:0] TolNeg   = -TolPos;
    localparam logic [CW-1:0]        FailLim  = CW'(FAIL_LIMIT);
    localparam logic [AW:0]          LastAcc  = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0]        LastAddr = AW'(DEPTH - 1);

    typedef enum logic [2:0] {StIdle, StRun, StFlush, StPass, StFail} state_e;

    state_e          state_q;
    logic            s1_valid_q;
    logic [BW-1:0]   s1_data_q;
    logic [AW-1:0]   s1_idx_q;
    logic            s2_valid_q;
    logic [MW-1:0]   s2_m_q;
    logic [AW-1:0]   s2_idx_q;
    logic [AW:0]     acc_cnt_q;
    logic [AW-1:0]   exp_addr_q;
    logic            done_q;
    logic            overflow_q;
    logic [CW-1:0]   fail_cnt_q;
    logic [AW:0]     beat_cnt_q;
    logic [AW-1:0]   ffb_q;

    logic [MW-1:0]   m_d;
    logic [DW-1:0]   diff;
    logic [CW:0]     fail_sum;
    logic [CW-1:0]   fail_cnt_d;
    logic            abort_d;

    // Per-half wrapped difference; fails when outside [-TOL, TOL] as a signed DW-bit value.
    always_comb begin
        m_d  = '0;
        diff = '0;
        for (int h = 0; h < NH; h++) begin
            diff = s1_data_q[h*DW +: DW] - exp_data_i[h*DW +: DW];
            if (($signed(diff) > TolPos) || ($signed(diff) < TolNeg)) begin
                m_d = m_d + MW'(1);
            end
        end
    end

    always_comb begin
        fail_sum   = {1'b0, fail_cnt_q} + (CW+1)'(s2_m_q);
        fail_cnt_d = fail_sum[CW] ? '1 : fail_sum[CW-1:0];
        abort_d    = s2_valid_q && (fail_cnt_d >= FailLim);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_m_q     <= '0;
            s2_idx_q   <= '0;
            acc_cnt_q  <= '0;
            exp_addr_q <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            fail_cnt_q <= '0;
            beat_cnt_q <= '0;
            ffb_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StPass, StFail: begin
                    if (start_i) begin
                        state_q    <= StRun;
                        s1_valid_q <= 1'b0;
                        s2_valid_q <= 1'b0;
                        acc_cnt_q  <= '0;
                        exp_addr_q <= '0;
                        overflow_q <= 1'b0;
                        fail_cnt_q <= '0;
                        beat_cnt_q <= '0;
                        ffb_q      <= '0;
                    end
                end
                StRun, StFlush: begin
                    s2_valid_q <= s1_valid_q;
                    s2_m_q     <= m_d;
                    s2_idx_q   <= s1_idx_q;
                    s1_valid_q <= 1'b0;
                    if (s2_valid_q) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        fail_cnt_q <= fail_cnt_d;
                        if ((fail_cnt_q == '0) && (s2_m_q != '0)) begin
                            ffb_q <= s2_idx_q;
                        end
                    end
                    if (state_q == StRun) begin
                        // Abort drops anything still in the pipe and wins over a new beat.
                        if (abort_d) begin
                            state_q    <= StFail;
                            done_q     <= 1'b1;
                            s1_valid_q <= 1'b0;
                            s2_valid_q <= 1'b0;
                        end else if (dut_valid_i) begin
                            s1_valid_q <= 1'b1;
                            s1_data_q  <= dut_data_i;
                            s1_idx_q   <= acc_cnt_q[AW-1:0];
                            acc_cnt_q  <= acc_cnt_q + 1'b1;
                            if (exp_addr_q != LastAddr) begin
                                exp_addr_q <= exp_addr_q + 1'b1;
                            end
                            if (acc_cnt_q == LastAcc) begin
                                state_q <= StFlush;
                            end
                        end
                    end else begin
                        if (dut_valid_i) begin
                            overflow_q <= 1'b1;
                        end
                        if (!s1_valid_q && !s2_valid_q) begin
                            state_q <= (fail_cnt_q == '0) ? StPass : StFail;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign exp_addr_o        = exp_addr_q;
    assign busy_o            = (state_q == StRun);
    assign done_o            = done_q;
    assign pass_o            = (state_q == StPass);
    assign fail_o            = (state_q == StFail);
    assign fail_cnt_o        = fail_cnt_q;
    assign beat_cnt_o        = beat_cnt_q;
    assign first_fail_beat_o = ffb_q;
    assign overflow_o        = overflow_q;

endmodule

// File: tb/tb_fas_stream_checker.sv
// Bench for fas_stream_checker: a small scalar instance (DEPTH=4, limit 3) and a 16-lane
// complex instance (DEPTH=8, limit 48), each fed from a synchronous expected-value memory.
module tb_fas_stream_checker;

    localparam int TolA = 3;
    localparam int LimA = 3;

    logic clk;
    logic rst;

    logic        start_a, valid_a, busy_a, done_a, pass_a, fail_a, ovf_a;
    logic [15:0] data_a, exp_a, fcnt_a;
    logic [1:0]  addr_a, ffb_a;
    logic [2:0]  bcnt_a;
    logic [15:0] mem_a [4];

    logic         start_b, valid_b, busy_b, done_b, pass_b, fail_b, ovf_b;
    logic [511:0] data_b, exp_b;
    logic [15:0]  fcnt_b;
    logic [2:0]   addr_b, ffb_b;
    logic [3:0]   bcnt_b;
    logic [511:0] mem_b [8];
    logic [511:0] dvb [8];

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int dcnt_a = 0, dedge_a = -1, dcnt_b = 0, dedge_b = -1;
    int be_a [4];
    int xe_a [3];
    int be_b [8];

    fas_stream_checker #(
        .DW(16), .LANES(1), .CPLX(0), .TOL(TolA), .FAIL_LIMIT(LimA), .DEPTH(4), .AW(2), .CW(16)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .dut_valid_i(valid_a), .dut_data_i(data_a),
        .exp_addr_o(addr_a), .exp_data_i(exp_a), .busy_o(busy_a), .done_o(done_a),
        .pass_o(pass_a), .fail_o(fail_a), .fail_cnt_o(fcnt_a), .beat_cnt_o(bcnt_a),
        .first_fail_beat_o(ffb_a), .overflow_o(ovf_a)
    );

    fas_stream_checker #(
        .DW(16), .LANES(16), .CPLX(1), .TOL(3), .FAIL_LIMIT(48), .DEPTH(8), .AW(3), .CW(16)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .dut_valid_i(valid_b), .dut_data_i(data_b),
        .exp_addr_o(addr_b), .exp_data_i(exp_b), .busy_o(busy_b), .done_o(done_b),
        .pass_o(pass_b), .fail_o(fail_b), .fail_cnt_o(fcnt_b), .beat_cnt_o(bcnt_b),
        .first_fail_beat_o(ffb_b), .overflow_o(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        exp_a <= mem_a[addr_a];
        exp_b <= mem_b[addr_b];
    end

    // edge_n counts rising edges; done_edge records the edge that raised done.
    always @(posedge clk) begin
        if (done_a) begin
            dcnt_a  <= dcnt_a + 1;
            dedge_a <= edge_n;
        end
        if (done_b) begin
            dcnt_b  <= dcnt_b + 1;
            dedge_b <= edge_n;
        end
        edge_n <= edge_n + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
        end
    endtask

    // Reference: wrapped 16-bit difference taken as signed, within +/-TolA passes.
    function automatic int nfail16(input logic [15:0] d, input logic [15:0] e);
        int df;
        df = int'(d) - int'(e);
        df = ((df % 65536) + 65536) % 65536;
        if (df >= 32768) df = df - 65536;
        return ((df > TolA) || (df < -TolA)) ? 1 : 0;
    endfunction

    function automatic logic [511:0] bump(input logic [511:0] v, input int nre, input int nim,
                                          input logic [15:0] amt);
        logic [511:0] r;
        r = v;
        for (int l = 0; l < nre; l++) r[511-l*32 -: 16] = r[511-l*32 -: 16] + amt;
        for (int l = nre; l < nre + nim; l++) r[495-l*32 -: 16] = r[495-l*32 -: 16] + amt;
        return r;
    endfunction

    task automatic run_a(input logic [3:0][15:0] ex, input logic [3:0][15:0] dv,
                         input logic [3:0][1:0] gaps, input int nx, input int xg,
                         output int d0);
        for (int i = 0; i < 4; i++) mem_a[i] = ex[i];
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        d0 = dcnt_a;
        for (int k = 0; k < 4; k++) begin
            repeat (int'(gaps[k])) @(negedge clk);
            valid_a = 1'b1; data_a = dv[k]; be_a[k] = edge_n + 1;
            @(negedge clk); valid_a = 1'b0;
        end
        for (int x = 0; x < nx; x++) begin
            repeat (xg) @(negedge clk);
            valid_a = 1'b1; data_a = 16'($urandom); xe_a[x] = edge_n + 1;
            @(negedge clk); valid_a = 1'b0;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic run_b(input int nb, output int d0);
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        d0 = dcnt_b;
        for (int k = 0; k < nb; k++) begin
            valid_b = 1'b1; data_b = dvb[k]; be_b[k] = edge_n + 1;
            @(negedge clk);
        end
        valid_b = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0][15:0] ex;
        logic [3:0][15:0] dv;
        int               nx;
        logic             pass;
        int               fc;
        int               bc;
        int               ffb;
        logic             ovf;
    } vec_t;

    vec_t tbl [6];
    logic [3:0][15:0] r_ex, r_dv;
    logic [3:0][1:0]  r_g;
    int d0, nx, xg, delta, cum, nf, m_ffb, m_bc, m_done;
    logic seen, abrt, m_ovf, m_pass;

    initial begin
        // Beat 0 is the rightmost word of each packed literal.
        tbl[0] = '{{16'h0040, 16'h0030, 16'h0020, 16'h0010},
                   {16'h0040, 16'h0030, 16'h0020, 16'h0010}, 0, 1'b1, 0, 4, 0, 1'b0};
        tbl[1] = '{{16'h0300, 16'h0000, 16'h0200, 16'h0100},
                   {16'h0300, 16'hFFFD, 16'h01FC, 16'h0103}, 0, 1'b0, 1, 4, 1, 1'b0};
        tbl[2] = '{{16'h0000, 16'h0000, 16'h0000, 16'h0000},
                   {16'hFFFC, 16'h0000, 16'h0004, 16'h7FFF}, 0, 1'b0, 3, 4, 0, 1'b0};
        tbl[3] = '{{16'h0000, 16'hFFFF, 16'h8000, 16'h1234},
                   {16'hFFFD, 16'h0002, 16'h7FFD, 16'h1231}, 0, 1'b1, 0, 4, 0, 1'b0};
        tbl[4] = '{{16'h0040, 16'h0030, 16'h0020, 16'h0010},
                   {16'h0040, 16'h0030, 16'h0020, 16'h0010}, 2, 1'b1, 0, 4, 0, 1'b1};
        tbl[5] = '{{16'h0000, 16'h0000, 16'h0000, 16'h0000},
                   {16'h0010, 16'h0000, 16'h0000, 16'h0000}, 0, 1'b0, 1, 4, 3, 1'b0};

        rst = 1'b1; start_a = 1'b0; valid_a = 1'b0; data_a = '0;
        start_b = 1'b0; valid_b = 1'b0; data_b = '0;
        for (int i = 0; i < 4; i++) mem_a[i] = '0;
        for (int i = 0; i < 8; i++) mem_b[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst.busy_a", busy_a, 0);
        chk("rst.done_a", done_a, 0);
        chk("rst.pass_a", pass_a, 0);
        chk("rst.fail_a", fail_a, 0);
        chk("rst.fcnt_a", fcnt_a, 0);
        chk("rst.bcnt_a", bcnt_a, 0);
        chk("rst.ffb_a", ffb_a, 0);
        chk("rst.ovf_a", ovf_a, 0);
        chk("rst.addr_a", addr_a, 0);
        chk("rst.outs_b", {busy_b, done_b, pass_b, fail_b, ovf_b, fcnt_b, bcnt_b, ffb_b, addr_b}, 0);

        for (int i = 0; i < 6; i++) begin
            run_a(tbl[i].ex, tbl[i].dv, '0, tbl[i].nx, 0, d0);
            chk($sformatf("tbl%0d.pass", i), pass_a, tbl[i].pass);
            chk($sformatf("tbl%0d.fail", i), fail_a, !tbl[i].pass);
            chk($sformatf("tbl%0d.fcnt", i), fcnt_a, tbl[i].fc);
            chk($sformatf("tbl%0d.bcnt", i), bcnt_a, tbl[i].bc);
            chk($sformatf("tbl%0d.ffb", i), ffb_a, tbl[i].ffb);
            chk($sformatf("tbl%0d.ovf", i), ovf_a, tbl[i].ovf);
            chk($sformatf("tbl%0d.latency", i), dedge_a - be_a[3], 3);
            chk($sformatf("tbl%0d.done_cnt", i), dcnt_a - d0, 1);
            chk($sformatf("tbl%0d.addr", i), addr_a, 3);
            chk($sformatf("tbl%0d.busy", i), busy_a, 0);
        end

        // Reset lands on the edge that takes beat 2; counters must come back clean.
        for (int i = 0; i < 4; i++) mem_a[i] = 16'(16 * (i + 1));
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; valid_a = 1'b1; data_a = 16'h0110;
        @(negedge clk); data_a = 16'h0120;
        @(negedge clk); data_a = 16'h0030; rst = 1'b1;
        @(negedge clk); rst = 1'b0; valid_a = 1'b0;
        chk("midrst.state", {busy_a, pass_a, fail_a, done_a, ovf_a}, 0);
        chk("midrst.fcnt", fcnt_a, 0);
        chk("midrst.bcnt", bcnt_a, 0);
        chk("midrst.addr", addr_a, 0);
        run_a(tbl[0].ex, tbl[0].dv, '0, 0, 0, d0);
        chk("midrst.pass", pass_a, 1);
        chk("midrst.fcnt2", fcnt_a, 0);
        chk("midrst.bcnt2", bcnt_a, 4);

        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 4; k++) begin
                r_ex[k] = 16'($urandom);
                if ($urandom_range(0, 9) < 6) delta = int'($urandom_range(0, 6)) - 3;
                else delta = int'($urandom_range(4, 65532));
                r_dv[k] = r_ex[k] + 16'(delta);
                r_g[k]  = 2'($urandom_range(0, 2));
            end
            nx = int'($urandom_range(0, 2));
            xg = int'($urandom_range(0, 3));
            run_a(r_ex, r_dv, r_g, nx, xg, d0);

            cum = 0; m_ffb = 0; seen = 1'b0; abrt = 1'b0; m_bc = 4; m_done = 0;
            for (int k = 0; k < 4; k++) begin
                if (!abrt) begin
                    nf = nfail16(r_dv[k], r_ex[k]);
                    if (nf > 0 && !seen) begin
                        seen = 1'b1; m_ffb = k;
                    end
                    cum += nf;
                    // Abort only if this beat's result lands while beats are still being accepted.
                    if (cum >= LimA && be_a[k] + 2 <= be_a[3]) begin
                        abrt = 1'b1; m_bc = k + 1; m_done = be_a[k] + 2;
                    end
                end
            end
            if (!abrt) m_done = be_a[3] + 3;
            m_ovf = 1'b0;
            if (!abrt) begin
                for (int x = 0; x < nx; x++) begin
                    if (xe_a[x] > be_a[3] && xe_a[x] <= be_a[3] + 3) m_ovf = 1'b1;
                end
            end
            m_pass = !abrt && (cum == 0);
            chk($sformatf("rnd%0d.pass", r), pass_a, m_pass);
            chk($sformatf("rnd%0d.fail", r), fail_a, !m_pass);
            chk($sformatf("rnd%0d.fcnt", r), fcnt_a, cum);
            chk($sformatf("rnd%0d.bcnt", r), bcnt_a, m_bc);
            chk($sformatf("rnd%0d.ffb", r), ffb_a, m_ffb);
            chk($sformatf("rnd%0d.ovf", r), ovf_a, m_ovf);
            chk($sformatf("rnd%0d.done_edge", r), dedge_a, m_done);
            chk($sformatf("rnd%0d.done_cnt", r), dcnt_a - d0, 1);
            if (!abrt) chk($sformatf("rnd%0d.addr", r), addr_a, 3);
        end

        for (int k = 0; k < 8; k++) begin
            for (int w = 0; w < 16; w++) mem_b[k][w*32 +: 32] = $urandom;
            dvb[k] = mem_b[k];
        end
        run_b(8, d0);
        chk("b_clean.pass", pass_b, 1);
        chk("b_clean.fcnt", fcnt_b, 0);
        chk("b_clean.bcnt", bcnt_b, 8);
        chk("b_clean.addr", addr_b, 7);

        dvb[2] = bump(mem_b[2], 5, 2, 16'd8);
        run_b(8, d0);
        chk("b_seven.fail", fail_b, 1);
        chk("b_seven.pass", pass_b, 0);
        chk("b_seven.fcnt", fcnt_b, 7);
        chk("b_seven.ffb", ffb_b, 2);
        chk("b_seven.bcnt", bcnt_b, 8);
        chk("b_seven.latency", dedge_b - be_b[7], 3);
        chk("b_seven.done_cnt", dcnt_b - d0, 1);

        for (int k = 0; k < 8; k++) dvb[k] = bump(mem_b[k], 8, 8, 16'd100);
        run_b(6, d0);
        chk("b_abort.fail", fail_b, 1);
        chk("b_abort.fcnt", fcnt_b, 48);
        chk("b_abort.bcnt", bcnt_b, 3);
        chk("b_abort.ovf", ovf_b, 0);
        chk("b_abort.ffb", ffb_b, 0);
        chk("b_abort.done_edge", dedge_b, be_b[2] + 2);
        chk("b_abort.done_cnt", dcnt_b - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fas_stream_checker.md
Name: fas_stream_checker

Overview:
- Synthesizable, parametrised result checker for FAS output streams (FIR scalar stream or FFT multi-lane complex beats).
- Compares every DUT output beat against an expected-value memory with a modular ±TOL tolerance.
- Keeps pass/fail statistics and aborts when a fail limit is reached.
- Sits beside the FAS core on FPGA prototypes and in gate-level regression, replacing per-bench comparison code.

Parameters:
- DW, 16, width of one scalar word (one real or imag half).
- LANES, 16, words per beat (1 for FIR, 16 for FFT).
- CPLX, 1, 1: each lane is {real,imag} 2*DW bits, each half checked independently; 0: lane is DW bits.
- TOL, 3, max allowed |signed(dut-exp) mod 2^DW| per half.
- FAIL_LIMIT, 48, failing-half count at which checking aborts.
- DEPTH, 64, number of beats expected.
- AW, 6, address width, ceil(log2(DEPTH)).
- CW, 16, width of statistic counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; arms checker from IDLE/PASS/FAIL.
- dut_valid  in  1  DUT beat valid.
- dut_data  in  LANES*(CPLX+1)*DW  DUT beat; lane 0 in MSBs; real above imag.
- exp_addr  out  AW  expected-memory beat address, registered.
- exp_data  in  LANES*(CPLX+1)*DW  expected beat, synchronous read, returned 1 cycle after exp_addr.
- busy  out  1  state RUN.
- done  out  1  1-cycle pulse on entering PASS or FAIL.
- pass  out  1  level, state PASS.
- fail  out  1  level, state FAIL.
- fail_cnt  out  CW  failing halves, saturating at 2^CW-1.
- beat_cnt  out  AW+1  beats checked.
- first_fail_beat  out  AW  beat index of first failure; valid when fail_cnt != 0.
- overflow  out  1  sticky: dut_valid seen after DEPTH beats consumed.

Behaviour:
- States IDLE, RUN, FLUSH, PASS, FAIL.
- Reset: state IDLE; all outputs 0; exp_addr 0.
- IDLE/PASS/FAIL + start: clear counters, first_fail_beat, overflow and exp_addr → RUN.
- start while RUN/FLUSH is ignored.
- RUN, dut_valid=1 at edge t:
  - Capture dut_data and beat index into stage-1 register.
  - exp_addr increments at t (back-to-back beats supported).
  - At edge t+1: compare stage-1 data with exp_data; register mismatch count m (0..LANES*(CPLX+1)).
  - At edge t+2: beat_cnt+1; fail_cnt += m, saturating. If fail_cnt was 0 and m>0, first_fail_beat ← index.
- Tolerance per half:
  - d = (dut - exp) mod 2^DW, interpreted signed.
  - Pass iff -TOL ≤ d ≤ TOL, so 16'h0000 vs 16'hFFFF passes with TOL≥1.
- When DEPTH beats have been accepted → FLUSH. Valid beats arriving in FLUSH set overflow and are not compared.
- FLUSH: wait until the pipeline is empty (2 cycles), then:
  - fail_cnt ≥ FAIL_LIMIT → FAIL; fail_cnt == 0 → PASS; otherwise FAIL.
- Abort: as soon as the updated fail_cnt ≥ FAIL_LIMIT during RUN → FAIL immediately. In-flight beats are discarded, and further dut_valid is ignored without setting overflow.
- done pulses exactly once per run, in the first cycle of PASS/FAIL.
- dut_valid in IDLE/PASS/FAIL: ignored; overflow only set in FLUSH.
- rst mid-run: everything returns to reset values next edge; an in-flight compare is lost.
- exp_addr holds at DEPTH-1 after the last beat and never wraps.

Test Plan:
- DEPTH=4, LANES=1, CPLX=0, exp={0010,0020,0030,0040}, dut identical, back-to-back after start → done at beat4+3 cycles; pass=1, fail_cnt=0, beat_cnt=4.
- Tolerance edges, TOL=3: dut=exp+3 passes; dut=exp-4 fails; exp=0000, dut=FFFD passes (wrap) → fail_cnt=1, first_fail_beat=index of the exp-4 beat.
- LANES=16, CPLX=1, one beat with 5 real and 2 imag halves off by 8 → fail_cnt=7 after one beat; end state FAIL.
- FAIL_LIMIT=48, every beat with 16 failing halves → fail asserted with fail_cnt=48 on the 3rd beat's update; 4th beat ignored, overflow=0.
- DEPTH=4, 6 valid beats → beats 5–6 set overflow=1; pass still 1 if first 4 match.
- Assert rst during beat 2, then start and run clean → counters restart from 0; pass=1, beat_cnt=DEPTH.
